// File: rtl/matrix_pkg.sv
// matrix_pkg: shared types and constants for the LED matrix scanner.
//   mode_e      display mode, advanced one step per accepted press
//   ROWS/COLS   matrix geometry
//   next_mode() FILL -> CHECKER -> SCROLL -> DIAG -> FILL
package matrix_pkg;

  localparam int unsigned ROWS = 8;
  localparam int unsigned COLS = 8;

  typedef enum logic [1:0] {
    FILL    = 2'd0,
    CHECKER = 2'd1,
    SCROLL  = 2'd2,
    DIAG    = 2'd3
  } mode_e;

  // Cyclic successor of a display mode.
  function automatic mode_e next_mode(input mode_e m);
    mode_e n;
    case (m)
      FILL:    n = CHECKER;
      CHECKER: n = SCROLL;
      SCROLL:  n = DIAG;
      default: n = FILL;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/matrix_scan_if.sv
// matrix_scan_if: press input and matrix drive outputs of matrix_scan.
//   i_step   one-cycle press pulse (master -> slave)
//   o_row    one-hot row enable
//   o_col    column data of the enabled row
//   o_mode   currently applied mode
//   o_frame  one-cycle pulse at each frame end
// slave = the scanner, master = whatever drives the press and watches the matrix.
interface matrix_scan_if;
  import matrix_pkg::*;

  logic            i_step;
  logic [ROWS-1:0] o_row;
  logic [COLS-1:0] o_col;
  logic [1:0]      o_mode;
  logic            o_frame;

  modport slave  (input  i_step, output o_row, output o_col, output o_mode, output o_frame);
  modport master (output i_step, input  o_row, input  o_col, input  o_mode, input  o_frame);

endinterface

// File: rtl/matrix_pattern.sv
// matrix_pattern: pure combinational column pattern for one row.
//   mode    display mode
//   row     row index 0..7
//   phase   animation phase 0..7
//   cols_c  column bits to light for that row
module matrix_pattern
  import matrix_pkg::*;
(
  input  mode_e           mode,
  input  logic [2:0]      row,
  input  logic [2:0]      phase,
  output logic [COLS-1:0] cols_c
);

  logic [2:0] sum;

  // row + phase wraps mod 8 by construction of the 3-bit sum.
  always_comb begin
    cols_c = '0;
    sum    = 3'(row + phase);
    case (mode)
      FILL:    cols_c = 8'hFF;
      CHECKER: cols_c = sum[0] ? 8'h55 : 8'hAA;
      SCROLL:  cols_c = 8'h01 << phase;
      DIAG:    cols_c = 8'h01 << sum;
      default: cols_c = '0;
    endcase
  end

endmodule

// File: rtl/matrix_scan.sv
// matrix_scan: 8x8 LED matrix row scanner with blanking, animation and
// frame-synchronous mode stepping.
//   clk, rst_n  clock and asynchronous active-low reset
//   bus.slave   i_step in; o_row, o_col, o_mode, o_frame out (all registered)
module matrix_scan
  import matrix_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1024,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter int unsigned ANIM_FRAMES  = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  matrix_scan_if.slave  bus
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FRM_W = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
  localparam int unsigned ROW_W = $clog2(ROWS);

  logic [DIV_W-1:0] div_cnt;
  logic [ROW_W-1:0] row_idx;
  logic [FRM_W-1:0] frame_cnt;
  logic [2:0]       phase;
  logic             pending;
  mode_e            mode;

  logic             row_adv_c;
  logic             frame_end_c;
  logic             blank_c;
  logic             apply_c;
  logic [COLS-1:0]  pat_c;

  assign row_adv_c   = (div_cnt == DIV_W'(SCAN_DIV - 1));
  assign frame_end_c = row_adv_c && (row_idx == ROW_W'(ROWS - 1));
  assign blank_c     = (32'(div_cnt) < BLANK_CYCLES);
  // A press landing on the boundary cycle itself is honoured immediately.
  assign apply_c     = frame_end_c && (pending || bus.i_step);

  matrix_pattern u_pattern (
    .mode   (mode),
    .row    (row_idx),
    .phase  (phase),
    .cols_c (pat_c)
  );

  // Counters, mode FSM and registered matrix drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt     <= '0;
      row_idx     <= '0;
      frame_cnt   <= '0;
      phase       <= '0;
      pending     <= 1'b0;
      mode        <= FILL;
      bus.o_row   <= '0;
      bus.o_col   <= '0;
      bus.o_mode  <= '0;
      bus.o_frame <= 1'b0;
    end else begin
      div_cnt <= row_adv_c ? '0 : div_cnt + DIV_W'(1);
      if (row_adv_c) row_idx <= row_idx + ROW_W'(1);

      // Presses are not queued: a second press before the boundary is absorbed.
      if (apply_c)         pending <= 1'b0;
      else if (bus.i_step) pending <= 1'b1;

      // Mode change takes priority over the animation step on the same edge.
      if (apply_c) begin
        mode      <= next_mode(mode);
        phase     <= '0;
        frame_cnt <= '0;
      end else if (frame_end_c) begin
        if (frame_cnt == FRM_W'(ANIM_FRAMES - 1)) begin
          frame_cnt <= '0;
          phase     <= phase + 3'd1;
        end else begin
          frame_cnt <= frame_cnt + FRM_W'(1);
        end
      end

      bus.o_row   <= blank_c ? '0 : (8'h01 << row_idx);
      bus.o_col   <= blank_c ? '0 : pat_c;
      bus.o_frame <= frame_end_c;
      bus.o_mode  <= mode;
    end
  end

endmodule

// File: tb/tb_matrix_scan.sv
// tb_matrix_scan: directed bench for matrix_scan with SCAN_DIV=8,
// BLANK_CYCLES=2, ANIM_FRAMES=2 (64-cycle frames, 128-cycle phases).
module tb_matrix_scan;
  import matrix_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   ecnt   = 0;   // rising edges since the last reset release

  always #5 clk = ~clk;

  matrix_scan_if bus ();

  matrix_scan #(
    .SCAN_DIV     (8),
    .BLANK_CYCLES (2),
    .ANIM_FRAMES  (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to rising edge e (counted from reset release), then settle 1 time unit.
  task automatic tick_to(input int e);
    while (ecnt < e) begin
      @(posedge clk);
      ecnt++;
    end
    #1;
  endtask

  // Press so that rising edge e samples i_step high.
  task automatic press_at(input int e);
    tick_to(e - 1);
    bus.i_step = 1'b1;
    tick_to(e);
    bus.i_step = 1'b0;
  endtask

  // Row enable after edge e: edge e registers counter state of cycle e-1.
  function automatic logic [7:0] exp_row(input int e);
    int s;
    int d;
    int r;
    logic [7:0] one;
    s   = e - 1;
    d   = s % 8;
    r   = (s / 8) % 8;
    one = 8'h01;
    return (d < 2) ? 8'h00 : (one << r);
  endfunction

  initial begin
    logic [7:0] er;
    bus.i_step = 1'b0;

    // Held in reset.
    #7;
    chk("rst_row",   bus.o_row, 8'h00);
    chk("rst_col",   bus.o_col, 8'h00);
    chk("rst_mode",  {6'd0, bus.o_mode}, 8'h00);
    chk("rst_frame", {7'd0, bus.o_frame}, 8'h00);
    #5;
    rst_n = 1'b1;
    ecnt  = 0;

    // Release: two blank edges, row 0 for six, two blank, then row 1.
    tick_to(1);  chk("rel_e1_row", bus.o_row, 8'h00); chk("rel_e1_col", bus.o_col, 8'h00);
    tick_to(2);  chk("rel_e2_row", bus.o_row, 8'h00);
    tick_to(3);  chk("rel_e3_row", bus.o_row, 8'h01); chk("rel_e3_col", bus.o_col, 8'hFF);
    tick_to(8);  chk("rel_e8_row", bus.o_row, 8'h01);
    tick_to(9);  chk("rel_e9_row", bus.o_row, 8'h00); chk("rel_e9_col", bus.o_col, 8'h00);
    tick_to(10); chk("rel_e10_row", bus.o_row, 8'h00);
    tick_to(11); chk("rel_e11_row", bus.o_row, 8'h02);

    // Full scan order and frame pulse over two frames.
    for (int e = 12; e <= 130; e++) begin
      tick_to(e);
      er = exp_row(e);
      chk("scan_row", bus.o_row, er);
      chk("scan_col", bus.o_col, (er == 8'h00) ? 8'h00 : 8'hFF);
      chk("scan_frame", {7'd0, bus.o_frame}, (((e - 1) % 64) == 63) ? 8'h01 : 8'h00);
    end

    // Single press mid-frame: applied at the boundary edge 192.
    press_at(140);
    tick_to(191); chk("adv_mode_pre", {6'd0, bus.o_mode}, 8'h00);
    tick_to(192); chk("adv_mode_edge", {6'd0, bus.o_mode}, 8'h00);
    tick_to(193); chk("adv_mode_post", {6'd0, bus.o_mode}, 8'h01);
    tick_to(195); chk("chk_r0_row", bus.o_row, 8'h01); chk("chk_r0_col", bus.o_col, 8'hAA);
    tick_to(203); chk("chk_r1_row", bus.o_row, 8'h02); chk("chk_r1_col", bus.o_col, 8'h55);

    // Two presses in one frame advance by one.
    press_at(211);
    press_at(221);
    tick_to(256); chk("dbl_mode_pre", {6'd0, bus.o_mode}, 8'h01);
    tick_to(257); chk("dbl_mode_post", {6'd0, bus.o_mode}, 8'h02);

    // SCROLL animation: phase steps every two frames, wraps after sixteen.
    tick_to(259);  chk("scr_p0_r0", bus.o_col, 8'h01);
    tick_to(300);  chk("scr_p0_r5_row", bus.o_row, 8'h20); chk("scr_p0_r5", bus.o_col, 8'h01);
    tick_to(387);  chk("scr_p1_r0", bus.o_col, 8'h02);
    tick_to(1155); chk("scr_p7_r0", bus.o_col, 8'h80);
    tick_to(1283); chk("scr_wrap_r0", bus.o_col, 8'h01);

    // Press on the exact frame_end cycle (state 1343) lands at edge 1344.
    tick_to(1343);
    bus.i_step = 1'b1;
    tick_to(1344);
    bus.i_step = 1'b0;
    chk("coin_mode_edge", {6'd0, bus.o_mode}, 8'h02);
    tick_to(1345); chk("coin_mode_post", {6'd0, bus.o_mode}, 8'h03);
    tick_to(1347); chk("diag_r0_row", bus.o_row, 8'h01); chk("diag_r0_col", bus.o_col, 8'h01);
    tick_to(1371); chk("diag_r3_row", bus.o_row, 8'h08); chk("diag_r3_col", bus.o_col, 8'h08);
    tick_to(1409); chk("coin_no_extra", {6'd0, bus.o_mode}, 8'h03);

    // Pending press then asynchronous reset between edges.
    press_at(1421);
    tick_to(1430); chk("pre_rst_row", bus.o_row, 8'h04); chk("pre_rst_col", bus.o_col, 8'h04);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_row",   bus.o_row, 8'h00);
    chk("arst_col",   bus.o_col, 8'h00);
    chk("arst_mode",  {6'd0, bus.o_mode}, 8'h00);
    chk("arst_frame", {7'd0, bus.o_frame}, 8'h00);
    #3;
    rst_n = 1'b1;
    ecnt  = 0;
    tick_to(2);  chk("rst2_e2_row", bus.o_row, 8'h00);
    tick_to(3);  chk("rst2_e3_row", bus.o_row, 8'h01); chk("rst2_e3_col", bus.o_col, 8'hFF);
    tick_to(64); chk("rst2_frame", {7'd0, bus.o_frame}, 8'h01);
    tick_to(65); chk("rst2_pending_lost", {6'd0, bus.o_mode}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
